// File: rtl/xbuf_pkg.sv
// Shared constants and encodings for the transfer-buffer slot scheduler.
package xbuf_pkg;

  localparam int MAX_BUFQ_DEPTH = 4;
  localparam int SLOT_W         = $clog2(MAX_BUFQ_DEPTH);
  localparam int CNT_W          = 4;
  localparam int ADDRESS_WIDTH  = 32;

  // Mover job direction as seen on cmd_dir.
  localparam logic DIR_RX2TBM = 1'b0;
  localparam logic DIR_TBM2TX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_BUSY  = 2'b10
  } xbuf_state_e;

endpackage

// File: rtl/xbuf_slot_ring.sv
// One slot ring: head/tail pointers with an occupancy count.
// Increments that would overflow or underflow the ring are dropped.
module xbuf_slot_ring
  import xbuf_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              inc_head_i,
  input  logic              inc_tail_i,
  output logic [SLOT_W-1:0] head_o,
  output logic [SLOT_W-1:0] tail_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [SLOT_W-1:0] head_q, head_d;
  logic [SLOT_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_s, pop_s;

  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign full_o  = (count_q == CNT_W'(MAX_BUFQ_DEPTH));
  assign push_s  = inc_head_i && !full_o;
  assign pop_s   = inc_tail_i && !empty_o;
  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

  // Advance pointers (natural wrap) and net the occupancy change.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_s) begin
      head_d = head_q + SLOT_W'(1);
    end else begin
      head_d = head_q;
    end
    if (pop_s) begin
      tail_d = tail_q + SLOT_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Ring state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= {SLOT_W{1'b0}};
      tail_q  <= {SLOT_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/xbuf_slot_scheduler.sv
// Sequences rx/tx slot rings and arbitrates the single TBM mover between
// rx-drain (slot -> TBM) and tx-fill (TBM -> slot) jobs.
module xbuf_slot_scheduler
  import xbuf_pkg::*;
(
  input  logic                     clock_host,
  input  logic                     reset,
  input  logic                     rx_commit,
  input  logic [ADDRESS_WIDTH-1:0] rx_commit_addr,
  input  logic                     tx_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] tx_req_addr,
  output logic                     tx_req_ready,
  input  logic                     tx_release,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_dir,
  output logic [SLOT_W-1:0]        cmd_slot,
  output logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic                     xfer_done,
  output logic [CNT_W-1:0]         rx_anum,
  output logic [CNT_W-1:0]         tx_anum,
  output logic                     busy,
  output logic                     rx_ovf,
  output logic                     tx_udf
);

  xbuf_state_e state_q, state_d;
  logic                     rr_last_q, rr_last_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     cmd_dir_q, cmd_dir_d;
  logic [SLOT_W-1:0]        cmd_slot_q, cmd_slot_d;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                     rx_ovf_q, tx_udf_q;
  logic [ADDRESS_WIDTH-1:0] rx_addr_q [MAX_BUFQ_DEPTH];
  logic [ADDRESS_WIDTH-1:0] tx_addr_q [MAX_BUFQ_DEPTH];

  // rx ring: head = host fill, tail = next to drain, count = filled slots.
  logic [SLOT_W-1:0] rx_head_s, rx_tail_s;
  logic [CNT_W-1:0]  rx_cnt_s;
  logic              rx_empty_s, rx_full_s;
  // tx pending ring: head = alloc, tail = issue, count = awaiting fill.
  logic [SLOT_W-1:0] txa_head_s, txa_tail_s;
  logic [CNT_W-1:0]  tx_pend_s;
  logic              txa_empty_s, txa_full_s;
  // tx ready ring: head follows issue, tail = host drain, count = readable.
  logic [SLOT_W-1:0] txb_head_s, txb_tail_s;
  logic [CNT_W-1:0]  tx_rdy_s;
  logic              txb_empty_s, txb_full_s;

  logic job_done_s, rx_done_s, tx_done_s, tx_accept_s, pick_tx_s;
  logic unused_s;

  assign job_done_s  = (state_q == ST_BUSY) && xfer_done;
  assign rx_done_s   = job_done_s && (cmd_dir_q == DIR_RX2TBM);
  assign tx_done_s   = job_done_s && (cmd_dir_q == DIR_TBM2TX);
  assign tx_accept_s = tx_req_valid && tx_req_ready;
  // On a tie, serve the direction that did not win last time.
  assign pick_tx_s   = !txa_empty_s && (rx_empty_s || (rr_last_q == DIR_RX2TBM));

  // Ring pointers/flags the scheduler does not consume.
  assign unused_s = ^{txa_full_s, txb_full_s, txb_head_s, txb_tail_s};

  xbuf_slot_ring u_rx_ring (
    .clk_i(clock_host), .reset_i(reset),
    .inc_head_i(rx_commit), .inc_tail_i(rx_done_s),
    .head_o(rx_head_s), .tail_o(rx_tail_s), .count_o(rx_cnt_s),
    .empty_o(rx_empty_s), .full_o(rx_full_s)
  );

  xbuf_slot_ring u_tx_pend_ring (
    .clk_i(clock_host), .reset_i(reset),
    .inc_head_i(tx_accept_s), .inc_tail_i(tx_done_s),
    .head_o(txa_head_s), .tail_o(txa_tail_s), .count_o(tx_pend_s),
    .empty_o(txa_empty_s), .full_o(txa_full_s)
  );

  xbuf_slot_ring u_tx_rdy_ring (
    .clk_i(clock_host), .reset_i(reset),
    .inc_head_i(tx_done_s), .inc_tail_i(tx_release),
    .head_o(txb_head_s), .tail_o(txb_tail_s), .count_o(tx_rdy_s),
    .empty_o(txb_empty_s), .full_o(txb_full_s)
  );

  assign rx_anum      = CNT_W'(MAX_BUFQ_DEPTH) - rx_cnt_s;
  assign tx_anum      = tx_rdy_s;
  assign tx_req_ready = ((tx_pend_s + tx_rdy_s) != CNT_W'(MAX_BUFQ_DEPTH));
  assign busy         = (state_q != ST_IDLE);
  assign cmd_valid    = cmd_valid_q;
  assign cmd_dir      = cmd_dir_q;
  assign cmd_slot     = cmd_slot_q;
  assign cmd_addr     = cmd_addr_q;
  assign rx_ovf       = rx_ovf_q;
  assign tx_udf       = tx_udf_q;

  // Mover FSM: pick a job in IDLE, hold the offer in ISSUE, wait for done in BUSY.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cmd_valid_d = cmd_valid_q;
    cmd_dir_d   = cmd_dir_q;
    cmd_slot_d  = cmd_slot_q;
    cmd_addr_d  = cmd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty_s || !txa_empty_s) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          if (pick_tx_s) begin
            cmd_dir_d  = DIR_TBM2TX;
            cmd_slot_d = txa_tail_s;
            cmd_addr_d = tx_addr_q[txa_tail_s];
            rr_last_d  = DIR_TBM2TX;
          end else begin
            cmd_dir_d  = DIR_RX2TBM;
            cmd_slot_d = rx_tail_s;
            cmd_addr_d = rx_addr_q[rx_tail_s];
            rr_last_d  = DIR_RX2TBM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_BUSY;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_BUSY: begin
        if (xfer_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // FSM, command and error-pulse registers.
  always_ff @(posedge clock_host) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 1'b0;
      cmd_slot_q  <= {SLOT_W{1'b0}};
      cmd_addr_q  <= {ADDRESS_WIDTH{1'b0}};
      rx_ovf_q    <= 1'b0;
      tx_udf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_slot_q  <= cmd_slot_d;
      cmd_addr_q  <= cmd_addr_d;
      rx_ovf_q    <= rx_commit && rx_full_s;
      tx_udf_q    <= tx_release && txb_empty_s;
    end
  end

  // Per-slot TBM addresses captured when a slot is committed or allocated.
  always_ff @(posedge clock_host) begin
    if (reset) begin
      for (int i = 0; i < MAX_BUFQ_DEPTH; i++) begin
        rx_addr_q[i] <= {ADDRESS_WIDTH{1'b0}};
        tx_addr_q[i] <= {ADDRESS_WIDTH{1'b0}};
      end
    end else begin
      if (rx_commit && !rx_full_s) begin
        rx_addr_q[rx_head_s] <= rx_commit_addr;
      end
      if (tx_accept_s) begin
        tx_addr_q[txa_head_s] <= tx_req_addr;
      end
    end
  end

endmodule

// File: tb/tb_xbuf_slot_scheduler.sv
// Self-checking bench for xbuf_slot_scheduler: directed vector table,
// directed multi-cycle sequences and a random run against a queue model.
module tb_xbuf_slot_scheduler;

  logic        clock_host;
  logic        reset;
  logic        rx_commit;
  logic [31:0] rx_commit_addr;
  logic        tx_req_valid;
  logic [31:0] tx_req_addr;
  logic        tx_req_ready;
  logic        tx_release;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [1:0]  cmd_slot;
  logic [31:0] cmd_addr;
  logic        xfer_done;
  logic [3:0]  rx_anum;
  logic [3:0]  tx_anum;
  logic        busy;
  logic        rx_ovf;
  logic        tx_udf;

  int n_cmp = 0;
  int n_bad = 0;

  xbuf_slot_scheduler dut (
    .clock_host(clock_host), .reset(reset),
    .rx_commit(rx_commit), .rx_commit_addr(rx_commit_addr),
    .tx_req_valid(tx_req_valid), .tx_req_addr(tx_req_addr),
    .tx_req_ready(tx_req_ready), .tx_release(tx_release),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_slot(cmd_slot), .cmd_addr(cmd_addr), .xfer_done(xfer_done),
    .rx_anum(rx_anum), .tx_anum(tx_anum), .busy(busy),
    .rx_ovf(rx_ovf), .tx_udf(tx_udf)
  );

  initial begin
    clock_host = 1'b0;
    forever #5 clock_host = ~clock_host;
  end

  // ---------------- reference model (queues of occupied slots) ----------------
  typedef struct {
    int          slot;
    logic [31:0] addr;
  } ent_t;

  ent_t        m_rxq[$];      // committed rx slots not yet written to TBM
  ent_t        m_txq[$];      // allocated tx slots not yet filled
  int          m_rx_head = 0;
  int          m_tx_alloc = 0;
  int          m_tx_rdy = 0;  // filled tx slots awaiting host drain
  int          m_phase = 0;   // 0 no job, 1 job offered, 2 job accepted
  bit          m_last_tx = 1'b1;
  logic        m_dir = 1'b0;
  int          m_slot = 0;
  logic [31:0] m_addr = 32'h0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  task automatic model_edge();
    int rx_n, tx_n, rdy;
    bit take_tx, acc;
    if (reset) begin
      m_rxq.delete(); m_txq.delete();
      m_rx_head = 0; m_tx_alloc = 0; m_tx_rdy = 0; m_phase = 0;
      m_last_tx = 1'b1; m_dir = 1'b0; m_slot = 0; m_addr = 32'h0;
      m_ovf = 1'b0; m_udf = 1'b0;
      return;
    end
    rx_n = m_rxq.size();
    tx_n = m_txq.size();
    rdy  = m_tx_rdy;
    acc  = tx_req_valid && (tx_n + rdy < 4);
    m_ovf = rx_commit && (rx_n == 4);
    m_udf = tx_release && (rdy == 0);
    if (m_phase == 0) begin
      if (rx_n > 0 || tx_n > 0) begin
        take_tx = (tx_n > 0) && (rx_n == 0 || !m_last_tx);
        if (take_tx) begin
          m_dir = 1'b1; m_slot = m_txq[0].slot; m_addr = m_txq[0].addr;
        end else begin
          m_dir = 1'b0; m_slot = m_rxq[0].slot; m_addr = m_rxq[0].addr;
        end
        m_last_tx = take_tx;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (cmd_ready) m_phase = 2;
    end else begin
      if (xfer_done) begin
        if (m_dir) begin
          void'(m_txq.pop_front());
          m_tx_rdy++;
        end else begin
          void'(m_rxq.pop_front());
        end
        m_phase = 0;
      end
    end
    if (rx_commit && rx_n < 4) begin
      m_rxq.push_back('{m_rx_head, rx_commit_addr});
      m_rx_head = (m_rx_head + 1) % 4;
    end
    if (acc) begin
      m_txq.push_back('{m_tx_alloc, tx_req_addr});
      m_tx_alloc = (m_tx_alloc + 1) % 4;
    end
    if (tx_release && rdy > 0) m_tx_rdy--;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [47:0] got, exp;
    got = {rx_anum, tx_anum, tx_req_ready, cmd_valid, busy, rx_ovf, tx_udf,
           cmd_dir, cmd_slot, cmd_addr};
    exp = {4'(4 - m_rxq.size()), 4'(m_tx_rdy), (m_txq.size() + m_tx_rdy < 4),
           (m_phase == 1), (m_phase != 0), m_ovf, m_udf, m_dir, 2'(m_slot), m_addr};
    chk("model", {16'h0, got}, {16'h0, exp});
  endtask

  // One clock: DUT and model both see the current inputs at the edge.
  task automatic step();
    @(posedge clock_host);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic clear_inputs();
    rx_commit = 1'b0; rx_commit_addr = 32'h0;
    tx_req_valid = 1'b0; tx_req_addr = 32'h0;
    tx_release = 1'b0; cmd_ready = 1'b0; xfer_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic        got_dir [8];
  logic [1:0]  got_slot[8];
  logic [31:0] got_addr[8];

  // Run n jobs with an always-ready mover, done three cycles after accept.
  task automatic do_jobs(input int n);
    cmd_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 30 && cmd_valid !== 1'b1; k++) step();
      chk("job_offered", {63'h0, cmd_valid}, 64'h1);
      got_dir[j] = cmd_dir; got_slot[j] = cmd_slot; got_addr[j] = cmd_addr;
      step();
      step();
      step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
    end
    cmd_ready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, rxc;
    logic [31:0] rxa;
    logic        crdy, xd;
    logic [3:0]  e_rxn, e_txn;
    logic        e_rdy, e_cv, e_busy, e_ovf, e_dir;
    logic [1:0]  e_slot;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vec[16];

  initial begin
    logic [46:0] got_v, exp_v;
    reset = 1'b1;
    clear_inputs();

    // rst rxc rxa crdy xd | rx tx rdy cv busy ovf dir slot addr
    vec[0]  = '{1'b1,1'b0,32'h0,   1'b0,1'b0, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h0};
    vec[1]  = '{1'b1,1'b0,32'h0,   1'b0,1'b0, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h0};
    vec[2]  = '{1'b0,1'b1,32'h1000,1'b0,1'b0, 4'd3,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h0};
    vec[3]  = '{1'b0,1'b0,32'h0,   1'b0,1'b0, 4'd3,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'h1000};
    vec[4]  = '{1'b0,1'b0,32'h0,   1'b1,1'b0, 4'd3,4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,32'h1000};
    vec[5]  = '{1'b0,1'b0,32'h0,   1'b0,1'b1, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h1000};
    vec[6]  = '{1'b0,1'b0,32'h0,   1'b0,1'b0, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h1000};
    vec[7]  = '{1'b0,1'b0,32'h0,   1'b0,1'b1, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h1000};
    vec[8]  = '{1'b1,1'b0,32'h0,   1'b0,1'b0, 4'd4,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h0};
    vec[9]  = '{1'b0,1'b1,32'hA000,1'b0,1'b0, 4'd3,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,32'h0};
    vec[10] = '{1'b0,1'b1,32'hA100,1'b0,1'b0, 4'd2,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'hA000};
    vec[11] = '{1'b0,1'b1,32'hA200,1'b0,1'b0, 4'd1,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'hA000};
    vec[12] = '{1'b0,1'b1,32'hA300,1'b0,1'b0, 4'd0,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'hA000};
    vec[13] = '{1'b0,1'b1,32'hA400,1'b0,1'b0, 4'd0,4'd0,1'b1,1'b1,1'b1,1'b1,1'b0,2'd0,32'hA000};
    vec[14] = '{1'b0,1'b0,32'h0,   1'b0,1'b0, 4'd0,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'hA000};
    vec[15] = '{1'b0,1'b0,32'h0,   1'b0,1'b0, 4'd0,4'd0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,32'hA000};

    for (int i = 0; i < 16; i++) begin
      reset = vec[i].rst; rx_commit = vec[i].rxc; rx_commit_addr = vec[i].rxa;
      cmd_ready = vec[i].crdy; xfer_done = vec[i].xd;
      step();
      got_v = {rx_anum, tx_anum, tx_req_ready, cmd_valid, busy, rx_ovf, cmd_dir,
               cmd_slot, cmd_addr};
      exp_v = {vec[i].e_rxn, vec[i].e_txn, vec[i].e_rdy, vec[i].e_cv, vec[i].e_busy,
               vec[i].e_ovf, vec[i].e_dir, vec[i].e_slot, vec[i].e_addr};
      chk($sformatf("vec%0d", i), {17'h0, got_v}, {17'h0, exp_v});
    end

    // Round-robin with both rings loaded: rx0, tx0, rx1, tx1.
    do_reset();
    for (int j = 0; j < 2; j++) begin
      rx_commit = 1'b1; rx_commit_addr = 32'h4000 + 32'(j) * 32'h100;
      tx_req_valid = 1'b1; tx_req_addr = 32'h5000 + 32'(j) * 32'h100;
      step();
    end
    clear_inputs();
    do_jobs(4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_dir%0d", j), {63'h0, got_dir[j]}, 64'(j % 2));
      chk($sformatf("rr_slot%0d", j), {62'h0, got_slot[j]}, 64'(j / 2));
      chk($sformatf("rr_addr%0d", j), {32'h0, got_addr[j]},
          64'(((j % 2) != 0 ? 32'h5000 : 32'h4000) + 32'(j / 2) * 32'h100));
    end

    // tx ring: fill, mover fills slots, host drains past empty.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      tx_req_valid = 1'b1; tx_req_addr = 32'h2000 + 32'(j) * 32'h100;
      step();
      chk($sformatf("tx_ready_after_req%0d", j), {63'h0, tx_req_ready}, 64'(j < 3));
    end
    clear_inputs();
    do_jobs(4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("tx_job_addr%0d", j), {32'h0, got_addr[j]},
          64'(32'h2000 + 32'(j) * 32'h100));
      chk($sformatf("tx_job_dir%0d", j), {63'h0, got_dir[j]}, 64'h1);
    end
    chk("tx_anum_full", {60'h0, tx_anum}, 64'd4);
    for (int j = 0; j < 5; j++) begin
      tx_release = 1'b1;
      step();
      chk($sformatf("tx_anum_rel%0d", j), {60'h0, tx_anum}, 64'(j < 4 ? 3 - j : 0));
      chk($sformatf("tx_udf_rel%0d", j), {63'h0, tx_udf}, 64'(j == 4));
    end
    tx_release = 1'b0;
    step();
    chk("tx_udf_clears", {63'h0, tx_udf}, 64'h0);

    // rx_commit coinciding with rx completion keeps rx_anum steady.
    do_reset();
    rx_commit = 1'b1; rx_commit_addr = 32'h6000; step();
    rx_commit_addr = 32'h6100; step();
    rx_commit = 1'b0;
    chk("rx_anum_two", {60'h0, rx_anum}, 64'd2);
    cmd_ready = 1'b1; step();
    cmd_ready = 1'b0; step();
    rx_commit = 1'b1; rx_commit_addr = 32'h6200; xfer_done = 1'b1; step();
    clear_inputs();
    chk("rx_anum_net", {60'h0, rx_anum}, 64'd2);

    // Slot index wrap over nine commit/drain rounds.
    do_reset();
    for (int j = 0; j < 9; j++) begin
      rx_commit = 1'b1; rx_commit_addr = 32'h7000 + 32'(j) * 32'h10; step();
      rx_commit = 1'b0;
      do_jobs(1);
      chk($sformatf("wrap_slot%0d", j), {62'h0, got_slot[0]}, 64'(j % 4));
      chk($sformatf("wrap_addr%0d", j), {32'h0, got_addr[0]},
          64'(32'h7000 + 32'(j) * 32'h10));
    end

    // Reset while BUSY, then a stale xfer_done.
    do_reset();
    rx_commit = 1'b1; rx_commit_addr = 32'h8000; step();
    rx_commit = 1'b0; step();
    cmd_ready = 1'b1; step();
    cmd_ready = 1'b0;
    chk("busy_before_reset", {63'h0, busy}, 64'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("reset_mid_job", {54'h0, rx_anum, tx_anum, cmd_valid, busy}, {54'h0, 4'd4, 4'd0, 2'b00});
    xfer_done = 1'b1; step();
    xfer_done = 1'b0;
    chk("stale_done", {54'h0, rx_anum, tx_anum, cmd_valid, busy}, {54'h0, 4'd4, 4'd0, 2'b00});

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      rx_commit      = ($urandom_range(0, 99) < 30);
      rx_commit_addr = $urandom;
      tx_req_valid   = ($urandom_range(0, 99) < 30);
      tx_req_addr    = $urandom;
      tx_release     = ($urandom_range(0, 99) < 30);
      cmd_ready      = ($urandom_range(0, 99) < 50);
      xfer_done      = ($urandom_range(0, 99) < 40);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbuf_slot_scheduler.md
Name: xbuf_slot_scheduler

Overview:
- Sequences the 4 KB slot rings of the transfer buffer between the host side and the TBM mover.
- Tracks rx slots: host-filled, waiting to be written to TBM.
- Tracks tx slots: allocated by host read requests, filled from TBM, then drained by the host.
- Arbitrates the single TBM mover between rx-drain and tx-fill jobs, and publishes the slot counts that the host reads as gs status.

Parameters:
- MAX_BUFQ_DEPTH, 4, slots per ring (power of 2, ≥2)
- SLOT_W, 2, slot index width = log2(MAX_BUFQ_DEPTH)
- ADDRESS_WIDTH, 32, TBM address width
- CNT_W, 4, width of count outputs

Ports:
- clock_host  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- rx_commit  in  1  pulse: host finished filling slot rx_head
- rx_commit_addr  in  ADDRESS_WIDTH  TBM destination for that slot
- tx_req_valid  in  1  host requests a TBM read into a tx slot
- tx_req_addr  in  ADDRESS_WIDTH  TBM source address
- tx_req_ready  out  1  request accepted this cycle when valid&ready
- tx_release  in  1  pulse: host finished draining slot tx_tail
- cmd_valid  out  1  job offered to TBM mover
- cmd_ready  in  1  mover accepts job
- cmd_dir  out  1  0 = rx slot→TBM write, 1 = TBM→tx slot read
- cmd_slot  out  SLOT_W  slot index of the job
- cmd_addr  out  ADDRESS_WIDTH  TBM address of the job
- xfer_done  in  1  pulse: accepted job complete
- rx_anum  out  CNT_W  free rx slots
- tx_anum  out  CNT_W  filled tx slots readable by host
- busy  out  1  job in flight (ISSUE or BUSY)
- rx_ovf  out  1  one-cycle pulse: rx_commit with rx_anum==0
- tx_udf  out  1  one-cycle pulse: tx_release with tx_anum==0

Behaviour:
- Reset values:
  - Outputs: rx_anum=MAX_BUFQ_DEPTH, tx_anum=0, tx_req_ready=1, cmd_valid=0, cmd_dir=0, cmd_slot=0, cmd_addr=0, busy=0, rx_ovf=0, tx_udf=0.
  - Internal: all pointers 0, rr_last=1 (rx wins first tie), state IDLE.
- Reset mid-job: in-flight job abandoned, cmd_valid drops next cycle, a later xfer_done is ignored.
- rx ring: rx_head (host fill), rx_tail (next to drain), rx_full count, rx_addr_q[slot].
  - rx_commit with rx_anum>0: store rx_addr_q[rx_head]=rx_commit_addr, rx_head++ (mod depth), rx_full++, rx_anum--.
  - rx_commit with rx_anum==0: no state change, rx_ovf=1 next cycle.
- tx ring: tx_alloc, tx_issue, tx_tail pointers; tx_free, tx_pend, tx_anum counts; tx_addr_q[slot].
  - tx_req_ready = (tx_free>0), combinational from registered count.
  - Accept: tx_addr_q[tx_alloc]=addr, tx_alloc++, tx_free--, tx_pend++.
  - tx_release with tx_anum>0: tx_tail++, tx_anum--, tx_free++.
  - tx_release with tx_anum==0: no state change, tx_udf=1 next cycle.
  - Invariant: tx_free+tx_pend+tx_anum == MAX_BUFQ_DEPTH.
- FSM states IDLE, ISSUE, BUSY:
  - IDLE: rx_cand = rx_full>0; tx_cand = tx_pend>0.
    - Only one candidate: pick it.
    - Both: pick opposite of rr_last.
    - Next cycle enter ISSUE with cmd_valid=1 and cmd_* loaded: rx → (0, rx_tail, rx_addr_q[rx_tail]); tx → (1, tx_issue, tx_addr_q[tx_issue]). rr_last=dir.
  - ISSUE: cmd_* held stable while cmd_valid & !cmd_ready. On cmd_ready: cmd_valid=0 next cycle, go to BUSY.
  - BUSY: wait for xfer_done.
    - rx job: rx_tail++, rx_full--, rx_anum++.
    - tx job: tx_issue++, tx_pend--, tx_anum++.
    - Return to IDLE.
  - xfer_done outside BUSY is ignored.
- Latency:
  - rx_commit at edge N → rx_anum updated at N+1; cmd_valid high at N+2 if IDLE.
  - xfer_done at edge M → counts updated at M+1, state IDLE at M+1; next cmd_valid no earlier than M+2.
- Simultaneous events:
  - Commit/request/release in the same cycle as xfer_done: all updates apply; counts take the net sum (e.g. rx_commit + rx done → rx_anum unchanged).
- Pointer arithmetic is modulo MAX_BUFQ_DEPTH, using natural SLOT_W-bit wrap.
- Counts never exceed MAX_BUFQ_DEPTH or go below 0.

Decomposition:
- Package xbuf_pkg holds:
  - MAX_BUFQ_DEPTH, SLOT_W, CNT_W
  - Direction codes DIR_RX2TBM=0, DIR_TBM2TX=1
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_BUSY
- Sub-module xbuf_slot_ring: one pointer pair plus count, with inc_head/inc_tail inputs and empty/full outputs.
  - Instantiated once for rx.
  - Instantiated twice for tx (alloc/issue, issue/tail).

Test Plan:
- After reset: rx_anum=4, tx_anum=0, tx_req_ready=1, cmd_valid=0. One rx_commit addr 0x1000 → rx_anum=3; cmd_valid=1 two cycles later with dir=0, slot=0, addr=0x1000. cmd_ready then xfer_done → rx_anum=4.
- Five rx_commits back-to-back, mover stalled (cmd_ready=0) → rx_anum 3,2,1,0, fifth gives rx_ovf pulse. Then cmd_* stays constant (slot 0) for the whole stall.
- rx_full=2 and tx_pend=2 simultaneously, mover always ready, done 3 cycles after accept → cmd_dir sequence 0,1,0,1; slots 0,0,1,1.
- Four tx requests (addrs 0x2000..0x2300) → tx_req_ready falls after the fourth. After 4 dones, tx_anum=4. Then tx_release ×5 → tx_anum goes to 0 and the fifth release gives a tx_udf pulse.
- rx_commit in the same cycle as rx xfer_done with rx_anum=2 → rx_anum stays 2; wrap test: 9 commit/drain cycles → slot indices 0,1,2,3,0,1,2,3,0.
- Reset asserted in BUSY, then xfer_done pulsed one cycle after reset releases → all counts at reset values, no count change, cmd_valid=0.
